// File: rtl/sum_bcd_display_if.sv
`default_nettype none
// ============================================================================
// Module      : sum_bcd_display_if
// Description : Bundle of the sum/BCD/display signals for sum_bcd_display.
//               master = producer of init/sum_in and consumer of the display
//               outputs; slave = the sum_bcd_display block.
//   init    capture strobe
//   sum_in  binary sum {co,zi} from the adder, WIDTH bits
//   busy    conversion in progress
//   done    one-cycle pulse, bcd holds a new result
//   bcd     held result, 4 BCD nibbles, [3:0] = units
//   sseg    segments {g,f,e,d,c,b,a}, active-low
//   an      digit anodes, active-low
// Revision    : 1.0 - initial release
// ============================================================================
interface sum_bcd_display_if #(
  parameter int WIDTH = 4
);
  logic             init;
  logic [WIDTH-1:0] sum_in;
  logic             busy;
  logic             done;
  logic [15:0]      bcd;
  logic [6:0]       sseg;
  logic [3:0]       an;

  modport master (
    output init, sum_in,
    input  busy, done, bcd, sseg, an
  );

  modport slave (
    input  init, sum_in,
    output busy, done, bcd, sseg, an
  );
endinterface
`default_nettype wire

// File: rtl/sum_bcd_display.sv
`default_nettype none
// ============================================================================
// Module      : sum_bcd_display
// Description : Captures the adder sum {co,zi} on an init strobe, converts it
//               to BCD with a sequential double-dabble FSM, holds the result
//               and scans it onto a 4-digit common-anode 7-segment display
//               with leading-zero blanking.
// Ports       : clk  - system clock, rising edge
//               rst  - asynchronous reset, active-high
//               bus  - sum_bcd_display_if.slave
//                        init, sum_in      (in)
//                        busy, done, bcd   (out)
//                        sseg, an          (out, active-low)
// Parameters  : WIDTH       - sum width incl. carry-out (1..13)
//               REFRESH_DIV - clk cycles per digit slot (>=2)
// Revision    : 1.0 - initial release
// ============================================================================
module sum_bcd_display #(
  parameter int WIDTH       = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  wire logic         clk,
  input  wire logic         rst,
  sum_bcd_display_if.slave  bus
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int NW = $clog2(WIDTH + 1);

  localparam logic [CW-1:0] c_cnt_max   = CW'(REFRESH_DIV - 1);
  localparam logic [NW-1:0] c_bit_count = NW'(WIDTH);
  localparam logic [NW-1:0] c_bit_last  = NW'(1);
  localparam logic [6:0]    c_seg_blank = 7'h7F;
  localparam logic [6:0]    c_seg_zero  = 7'h40;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Conversion state
  // --------------------------------------------------------------------------
  state_t           r_state;
  logic [WIDTH-1:0] r_shift;   // remaining binary bits, MSB shifted out first
  logic [15:0]      r_scr;     // BCD scratch accumulator
  logic [NW-1:0]    r_bits;    // shifts still to perform
  logic             r_busy;
  logic             r_done;
  logic [15:0]      r_bcd;     // held, displayed result

  // Scan state
  logic [CW-1:0]    r_cnt;
  logic [1:0]       r_idx;
  logic [3:0]       r_an;
  logic [6:0]       r_sseg;

  // Double-dabble correction: +3 on every scratch nibble >= 5 before the shift
  logic [15:0]      w_adj;

  always_comb begin
    w_adj = r_scr;
    for (int i = 0; i < 4; i++) begin
      if (r_scr[i*4 +: 4] >= 4'd5) begin
        w_adj[i*4 +: 4] = r_scr[i*4 +: 4] + 4'd3;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Conversion FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_scr   <= '0;
      r_bits  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_bcd   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.init) begin
            r_shift <= bus.sum_in;
            r_scr   <= '0;
            r_bits  <= c_bit_count;
            r_busy  <= 1'b1;
            r_state <= ST_CONV;
          end
        end
        ST_CONV: begin
          r_scr   <= {w_adj[14:0], r_shift[WIDTH-1]};
          r_shift <= r_shift << 1;
          r_bits  <= r_bits - c_bit_last;
          if (r_bits == c_bit_last) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Publishing happens in one edge so the display never sees a
          // partially converted value.
          r_bcd   <= r_scr;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Display scan
  // --------------------------------------------------------------------------
  logic [3:0] w_nib;
  logic       w_blank;
  logic [3:0] w_an;
  logic [6:0] w_sseg;

  function automatic logic [6:0] seg_encode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = c_seg_blank;
    endcase
    return s;
  endfunction

  always_comb begin
    w_nib   = r_bcd[3:0];
    w_blank = 1'b0;
    case (r_idx)
      2'd0: begin
        w_nib   = r_bcd[3:0];
        w_blank = 1'b0;
      end
      2'd1: begin
        w_nib   = r_bcd[7:4];
        w_blank = (r_bcd[15:4] == 12'd0);
      end
      2'd2: begin
        w_nib   = r_bcd[11:8];
        w_blank = (r_bcd[15:8] == 8'd0);
      end
      default: begin
        w_nib   = r_bcd[15:12];
        w_blank = (r_bcd[15:12] == 4'd0);
      end
    endcase
    w_an   = w_blank ? 4'hF : ~(4'b0001 << r_idx);
    w_sseg = w_blank ? c_seg_blank : seg_encode(w_nib);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_idx  <= 2'd0;
      r_an   <= 4'b1110;
      r_sseg <= c_seg_zero;
    end else begin
      if (r_cnt == c_cnt_max) begin
        r_cnt <= '0;
        r_idx <= r_idx + 2'd1;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
      r_an   <= w_an;
      r_sseg <= w_sseg;
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.bcd  = r_bcd;
  assign bus.an   = r_an;
  assign bus.sseg = r_sseg;

endmodule
`default_nettype wire

// File: tb/tb_sum_bcd_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_sum_bcd_display
// Description : Self-checking bench for sum_bcd_display. Two instances:
//               u4 (WIDTH=4, REFRESH_DIV=3) and u8 (WIDTH=8, REFRESH_DIV=4).
//               Expected BCD and display contents come from decimal
//               arithmetic on the captured sum.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sum_bcd_display;

  logic clk;
  logic rst;

  sum_bcd_display_if #(.WIDTH(4)) bus4 ();
  sum_bcd_display_if #(.WIDTH(8)) bus8 ();

  sum_bcd_display #(.WIDTH(4), .REFRESH_DIV(3)) u4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  sum_bcd_display #(.WIDTH(8), .REFRESH_DIV(4)) u8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // ---------------- reference model ----------------
  function automatic int digit(input int v, input int k);
    int p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    return (v / p) % 10;
  endfunction

  function automatic logic [15:0] ref_bcd(input int v);
    return {4'(digit(v, 3)), 4'(digit(v, 2)), 4'(digit(v, 1)), 4'(digit(v, 0))};
  endfunction

  function automatic bit ref_blank(input int v, input int k);
    int p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    return (k > 0) && (v < p);
  endfunction

  // ---------------- access helpers ----------------
  function automatic int width_of(input bit sel);
    return sel ? 8 : 4;
  endfunction

  function automatic int div_of(input bit sel);
    return sel ? 4 : 3;
  endfunction

  function automatic logic get_busy(input bit sel);
    return sel ? bus8.busy : bus4.busy;
  endfunction

  function automatic logic get_done(input bit sel);
    return sel ? bus8.done : bus4.done;
  endfunction

  function automatic logic [15:0] get_bcd(input bit sel);
    return sel ? bus8.bcd : bus4.bcd;
  endfunction

  function automatic logic [3:0] get_an(input bit sel);
    return sel ? bus8.an : bus4.an;
  endfunction

  function automatic logic [6:0] get_sseg(input bit sel);
    return sel ? bus8.sseg : bus4.sseg;
  endfunction

  task automatic drive(input bit sel, input logic ini, input int v);
    if (sel) begin
      bus8.init   = ini;
      bus8.sum_in = 8'(v);
    end else begin
      bus4.init   = ini;
      bus4.sum_in = 4'(v);
    end
  endtask

  task automatic set_init(input bit sel, input logic ini);
    if (sel) bus8.init = ini;
    else     bus4.init = ini;
  endtask

  // One conversion from IDLE; optionally scrambles sum_in while busy.
  task automatic do_conv(input bit sel, input int v, input bit wiggle, input string name);
    int w = width_of(sel);
    int errs = 0;
    logic [15:0] exp_b = ref_bcd(v);
    @(posedge clk); #1;
    drive(sel, 1'b1, v);
    @(posedge clk); #1;                         // E0 sampled
    set_init(sel, 1'b0);
    for (int c = 0; c <= w; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      if (wiggle) drive(sel, 1'b0, int'($urandom));
      if (get_busy(sel) !== 1'b1 || get_done(sel) !== 1'b0) errs++;
    end
    n_checks++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL %s busy-window: %0d bad cycles, busy=%b done=%b required busy=1 done=0",
               name, errs, get_busy(sel), get_done(sel));
    end
    @(posedge clk); #1;                         // E0+WIDTH+1
    n_checks++;
    if (get_done(sel) !== 1'b1 || get_busy(sel) !== 1'b0 || get_bcd(sel) !== exp_b) begin
      n_fail++;
      $display("FAIL %s result: done=%b busy=%b bcd=%h, required done=1 busy=0 bcd=%h (sum %0d)",
               name, get_done(sel), get_busy(sel), get_bcd(sel), exp_b, v);
    end
    @(posedge clk); #1;
    n_checks++;
    if (get_done(sel) !== 1'b0 || get_bcd(sel) !== exp_b) begin
      n_fail++;
      $display("FAIL %s done-pulse-width: done=%b bcd=%h, required done=0 bcd=%h",
               name, get_done(sel), get_bcd(sel), exp_b);
    end
  endtask

  // Records the display for several scan rounds, aligns on the start of
  // slot 0 and compares one full round against the model for value v.
  task automatic check_scan(input bit sel, input int v, input string name);
    int d = div_of(sel);
    int n = 12 * d;
    int start = -1;
    int errs = 0;
    logic [3:0] aq [$];
    logic [6:0] sq [$];
    logic [3:0] bad_an, bad_ean;
    logic [6:0] bad_s, bad_es;
    bad_an = '0; bad_ean = '0; bad_s = '0; bad_es = '0;
    for (int t = 0; t < n; t++) begin
      @(posedge clk); #1;
      aq.push_back(get_an(sel));
      sq.push_back(get_sseg(sel));
    end
    for (int t = 1; t + 4 * d <= n && start < 0; t++) begin
      if (aq[t] == 4'b1110 && aq[t-1] != 4'b1110) start = t;
    end
    n_checks++;
    if (start < 0) begin
      n_fail++;
      $display("FAIL %s scan-align: slot 0 (an=1110) run start not found, last an=%b", name, aq[n-1]);
    end else begin
      for (int t = 0; t < 4 * d; t++) begin
        int k = t / d;
        logic [3:0] ean;
        logic [6:0] es;
        if (ref_blank(v, k)) begin
          ean = 4'hF;
          es  = 7'h7F;
        end else begin
          ean = ~(4'b0001 << k);
          es  = seg_tab[digit(v, k)];
        end
        if (aq[start+t] !== ean || sq[start+t] !== es) begin
          if (errs == 0) begin
            bad_an = aq[start+t]; bad_ean = ean; bad_s = sq[start+t]; bad_es = es;
          end
          errs++;
        end
      end
      if (errs != 0) begin
        n_fail++;
        $display("FAIL %s scan: %0d bad cycles, first an=%b sseg=%h, required an=%b sseg=%h (value %0d)",
                 name, errs, bad_an, bad_s, bad_ean, bad_es, v);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 0);
    drive(1'b1, 1'b0, 0);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus4.an !== 4'b1110 || bus4.sseg !== 7'b1000000 || bus4.bcd !== 16'h0000 ||
        bus4.busy !== 1'b0 || bus4.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: an=%b sseg=%b bcd=%h busy=%b done=%b, required 1110 1000000 0000 0 0",
               bus4.an, bus4.sseg, bus4.bcd, bus4.busy, bus4.done);
    end
    rst = 1'b0;
    // Load a nonzero result, then reset between edges.
    do_conv(1'b0, 15, 1'b0, "reset_preload");
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus4.an !== 4'b1110 || bus4.sseg !== 7'b1000000 || bus4.bcd !== 16'h0000 ||
        bus4.busy !== 1'b0 || bus4.done !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: an=%b sseg=%b bcd=%h busy=%b done=%b, required 1110 1000000 0000 0 0",
               bus4.an, bus4.sseg, bus4.bcd, bus4.busy, bus4.done);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_max_sum();
    do_conv(1'b0, 15, 1'b0, "sum15");
    check_scan(1'b0, 15, "sum15");
  endtask

  task automatic test_zero_sum();
    do_conv(1'b0, 0, 1'b0, "sum0");
    check_scan(1'b0, 0, "sum0");
  endtask

  task automatic test_init_while_busy();
    int dones = 0;
    int late_busy = 0;
    logic done_at5 = 1'b0;
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 9);
    for (int t = 0; t < 16; t++) begin
      @(posedge clk); #1;
      if (bus4.done === 1'b1) dones++;
      if (t == 5) done_at5 = bus4.done;
      if (t >= 6 && bus4.busy !== 1'b0) late_busy++;
      case (t)
        0: set_init(1'b0, 1'b0);
        2: drive(1'b0, 1'b1, 6);
        3: set_init(1'b0, 1'b0);
        4: set_init(1'b0, 1'b1);   // lands on the DONE cycle
        5: set_init(1'b0, 1'b0);
        default: ;
      endcase
    end
    n_checks++;
    if (dones != 1 || done_at5 !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_init_done: done count=%0d done@E0+5=%b, required 1 and 1", dones, done_at5);
    end
    n_checks++;
    if (late_busy != 0 || bus4.bcd !== 16'h0009) begin
      n_fail++;
      $display("FAIL busy_init_result: late busy cycles=%0d bcd=%h, required 0 and 0009",
               late_busy, bus4.bcd);
    end
  endtask

  task automatic test_abort();
    int bad = 0;
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 13);
    @(posedge clk); #1;
    set_init(1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus4.busy !== 1'b0 || bus4.done !== 1'b0 || bus4.bcd !== 16'h0000) begin
      n_fail++;
      $display("FAIL abort: busy=%b done=%b bcd=%h, required 0 0 0000", bus4.busy, bus4.done, bus4.bcd);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(posedge clk); #1;
      if (bus4.done !== 1'b0 || bus4.busy !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL abort_quiet: %0d cycles with busy/done after abort, required 0", bad);
    end
    do_conv(1'b0, 13, 1'b0, "after_abort");
  endtask

  task automatic test_back_to_back();
    int w = 4;
    int first_done = -1;
    int second_done = -1;
    int restart = -1;
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 12);
    for (int t = 0; t < 20; t++) begin
      @(posedge clk); #1;
      if (bus4.done === 1'b1) begin
        if (first_done < 0) first_done = t;
        else if (second_done < 0) second_done = t;
      end
      if (first_done >= 0 && restart < 0 && t > first_done && bus4.busy === 1'b1) restart = t;
      if (t == w + 1) drive(1'b0, 1'b1, 7);   // second capture value
      if (second_done >= 0) set_init(1'b0, 1'b0);
    end
    set_init(1'b0, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    n_checks++;
    if (first_done != w + 1 || restart != w + 2 || second_done != 2 * w + 3) begin
      n_fail++;
      $display("FAIL back_to_back: done@%0d restart@%0d done2@%0d, required %0d %0d %0d",
               first_done, restart, second_done, w + 1, w + 2, 2 * w + 3);
    end
    // With init held, later restarts keep running; wait until idle and check the last value.
    n_checks++;
    if (bus4.busy !== 1'b0 || bus4.bcd !== ref_bcd(7)) begin
      n_fail++;
      $display("FAIL back_to_back_value: busy=%b bcd=%h, required 0 %h", bus4.busy, bus4.bcd, ref_bcd(7));
    end
  endtask

  task automatic test_wide();
    do_conv(1'b1, 255, 1'b0, "wide255");
    check_scan(1'b1, 255, "wide255");
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      int v4 = int'($urandom_range(0, 15));
      int v8 = int'($urandom_range(0, 255));
      do_conv(1'b0, v4, 1'b1, "rand4");
      if (i < 4) check_scan(1'b0, v4, "rand4");
      do_conv(1'b1, v8, 1'b1, "rand8");
      if (i < 3) check_scan(1'b1, v8, "rand8");
    end
  endtask

  initial begin
    test_reset();
    test_max_sum();
    test_zero_sum();
    test_init_while_busy();
    test_abort();
    test_back_to_back();
    test_wide();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
